// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned NreqDefault  = 4;
    localparam int unsigned DwDefault    = 8;
    localparam int unsigned BurstDefault = 4;

    // Wide enough for the largest legal BURST (15).
    localparam int unsigned CntW = 4;

    typedef enum logic {
        StIdle,
        StBurst
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: the first requester after 'last', wrapping around.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = IW'((32'(last) + i) % NREQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// granting bursts of up to BURST beats with one idle cycle between grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NreqDefault,
    parameter int unsigned DW    = DwDefault,
    parameter int unsigned BURST = BurstDefault
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic               fifo_full,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_din,
    output logic               busy
);

    localparam int unsigned     IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(BURST - 1);

    arb_state_e      state_q;
    logic [NREQ-1:0] gnt_q;
    logic [CntW-1:0] cnt_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   owner_q;
    logic [NREQ-1:0] winner;
    logic [IW-1:0]   win_idx;
    logic            beat;

    rr_pick #(
        .NREQ(NREQ),
        .IW  (IW)
    ) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .winner(winner)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner[i]) win_idx = IW'(i);
        end
    end

    // A beat needs the owner still requesting and room in the FIFO.
    assign beat     = (state_q == StBurst) && req[owner_q] && !fifo_full;
    assign fifo_we  = beat;
    assign fifo_din = wdata[owner_q*DW +: DW];
    assign ack      = beat ? gnt_q : '0;
    assign gnt      = gnt_q;
    assign busy     = (state_q == StBurst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            owner_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q <= StBurst;
                        gnt_q   <= winner;
                        owner_q <= win_idx;
                        cnt_q   <= '0;
                    end
                end
                StBurst: begin
                    // Leave after the final beat, or as soon as the owner withdraws.
                    if (!req[owner_q] || (beat && cnt_q == LastBeat)) begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        last_q  <= owner_q;
                    end else if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: scoreboarded producers, a cycle-level round-robin/burst
// model and a 16-deep FIFO model hanging off the write port.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic               fifo_full;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               fifo_we;
    logic [DW-1:0]      fifo_din;
    logic               busy;

    fifo_wr_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .BURST(BURST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wdata    (wdata),
        .fifo_full(fifo_full),
        .gnt      (gnt),
        .ack      (ack),
        .fifo_we  (fifo_we),
        .fifo_din (fifo_din),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Producer side (main thread only)
    logic [DW-1:0]   pend  [NREQ][$];
    logic [DW-1:0]   exp_q [NREQ][$];
    logic [DW-1:0]   ff_q  [$];
    int              rd_count = 0;
    logic [NREQ-1:0] drop = '0;
    logic            full_force = 1'b0;
    logic            use_fifo = 1'b0;
    int              rd_pct = 50;

    // Monitor side (monitor process only)
    int              rd_idx [NREQ];
    int              glog [$];
    int              wcount = 0;
    logic [NREQ-1:0] ack_seen;
    logic            we_seen;
    logic [DW-1:0]   din_seen;
    logic [NREQ-1:0] m_gnt;
    logic [NREQ-1:0] m_req;
    int              m_last;
    int              m_beats;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] rr_model(input logic [NREQ-1:0] r, input int last);
        logic [NREQ-1:0] w;
        w = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int j = (last + k) % NREQ;
            if (r[j]) begin
                w[j] = 1'b1;
                return w;
            end
        end
        return w;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return 0;
    endfunction

    // Model: IDLE grants the round-robin winner of the request seen at the edge; a burst
    // ends after BURST beats or after a cycle where the owner did not request.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {gnt, ack, fifo_we, busy}, '0);
            m_gnt    = '0;
            m_req    = '0;
            m_last   = NREQ - 1;
            m_beats  = 0;
            ack_seen = '0;
            we_seen  = 1'b0;
            din_seen = '0;
            for (int i = 0; i < NREQ; i++) rd_idx[i] = exp_q[i].size();
        end else begin
            logic [NREQ-1:0] e_gnt;
            logic            e_we;
            int              ow;
            if (m_gnt == '0) begin
                e_gnt = rr_model(m_req, m_last);
            end else begin
                ow = onehot_idx(m_gnt);
                if (m_beats == BURST || !m_req[ow]) begin
                    e_gnt   = '0;
                    m_last  = ow;
                    m_beats = 0;
                end else begin
                    e_gnt = m_gnt;
                end
            end
            check("gnt", gnt, e_gnt);
            check("busy", busy, e_gnt != '0);
            if (m_gnt == '0 && e_gnt != '0) glog.push_back(onehot_idx(e_gnt));
            e_we = (e_gnt != '0) && ((e_gnt & req) != '0) && !fifo_full;
            check("fifo_we", fifo_we, e_we);
            check("we_while_full", fifo_we & fifo_full, 1'b0);
            check("ack", ack, e_we ? e_gnt : '0);
            if (e_we) begin
                ow = onehot_idx(e_gnt);
                m_beats++;
                wcount++;
                tests++;
                if (rd_idx[ow] >= exp_q[ow].size()) begin
                    fails++;
                    $display("FAIL fifo_din_unexpected: beat from producer %0d data %0h, required none",
                             ow, fifo_din);
                end else if (fifo_din !== exp_q[ow][rd_idx[ow]]) begin
                    fails++;
                    $display("FAIL fifo_din: producer %0d got %0h, required %0h (t=%0t)",
                             ow, fifo_din, exp_q[ow][rd_idx[ow]], $time);
                    rd_idx[ow]++;
                end else begin
                    rd_idx[ow]++;
                end
            end
            ack_seen = ack;
            we_seen  = fifo_we;
            din_seen = fifo_din;
            m_gnt    = e_gnt;
            m_req    = req;
        end
    end

    task automatic present();
        for (int i = 0; i < NREQ; i++) begin
            req[i]            = (pend[i].size() != 0) && !drop[i];
            wdata[i*DW +: DW] = (pend[i].size() != 0) ? pend[i][0] : '0;
        end
        fifo_full = use_fifo ? (ff_q.size() >= DEPTH) : full_force;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (ack_seen[i] && pend[i].size() != 0) void'(pend[i].pop_front());
        if (use_fifo && we_seen) ff_q.push_back(din_seen);
        if (use_fifo && ff_q.size() != 0 && $urandom_range(99) < rd_pct) begin
            void'(ff_q.pop_front());
            rd_count++;
        end
        present();
    endtask

    task automatic load(input int i, input logic [DW-1:0] b);
        pend[i].push_back(b);
        exp_q[i].push_back(b);
    endtask

    task automatic drain(input int bound, input string name);
        int n = 0;
        while ((req != '0 || busy) && n < bound) begin
            step();
            n++;
        end
        tests++;
        if (n >= bound) begin
            fails++;
            $display("FAIL %s_timeout: still active after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic wait_beats(input int base, input int target, input string name);
        int n = 0;
        while (wcount - base < target && n < 50) begin
            step();
            n++;
        end
        check(name, wcount - base, target);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i].delete();
        drop       = '0;
        full_force = 1'b0;
        present();
        #1;
        check("reset_async_gnt", gnt, '0);
        check("reset_async_we", fifo_we, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int g0, wc0, r0, hold;
        int order [5] = '{0, 1, 2, 3, 0};
        rst_n     = 1'b1;
        req       = '0;
        wdata     = '0;
        fifo_full = 1'b0;
        #2;
        do_reset();

        // Single producer, one full burst of 0x11..0x14
        g0 = glog.size(); wc0 = wcount; hold = 0;
        for (int k = 0; k < 4; k++) load(0, 8'(8'h11 + k));
        present();
        for (int c = 0; c < 8; c++) begin
            step();
            if (gnt == 4'b0001) hold++;
        end
        check("single_gnt_cycles", hold, 4);
        check("single_beats", wcount - wc0, 4);
        check("single_grants", glog.size() - g0, 1);

        // All producers requesting: order 0,1,2,3,0 from reset
        do_reset();
        g0 = glog.size();
        for (int k = 0; k < 8; k++) load(0, 8'(8'h20 + k));
        for (int i = 1; i < NREQ; i++)
            for (int k = 0; k < 4; k++) load(i, 8'(i * 16 + 8'h30 + k));
        present();
        drain(100, "rr4");
        check("rr4_grants", glog.size() - g0, 5);
        for (int j = 0; j < 5; j++)
            if (glog.size() > g0 + j) check("rr4_order", glog[g0 + j], order[j]);

        // Owner 2 stalled by a full FIFO after its second beat
        wc0 = wcount;
        for (int k = 0; k < 4; k++) load(2, 8'(8'h40 + k));
        present();
        wait_beats(wc0, 2, "full_reach_beat2");
        full_force = 1'b1;
        present();
        for (int c = 0; c < 3; c++) begin
            step();
            check("full_no_write", wcount - wc0, 2);
        end
        check("full_hold_gnt", gnt, 4'b0100);
        full_force = 1'b0;
        present();
        drain(20, "full");
        check("full_total", wcount - wc0, 4);

        // Owner 1 withdraws after one beat; 0 and 2 waiting -> 2 wins
        wc0 = wcount;
        for (int k = 0; k < 3; k++) load(1, 8'(8'h50 + k));
        present();
        wait_beats(wc0, 1, "drop_first_beat");
        drop[1] = 1'b1;
        load(0, 8'h60);
        load(2, 8'h70);
        present();
        step();
        check("drop_exit_gnt", gnt, '0);
        step();
        check("drop_next_gnt", gnt, 4'b0100);
        drop = '0;
        present();
        drain(100, "drop");

        // Reset mid-burst, then priority restarts after producer 3
        wc0 = wcount;
        for (int k = 0; k < 4; k++) load(0, 8'(8'h80 + k));
        present();
        wait_beats(wc0, 2, "abort_beat2");
        do_reset();
        check("abort_beats", wcount - wc0, 2);
        load(3, 8'h90);
        present();
        step();
        check("post_reset_p3", gnt, 4'b1000);
        drain(20, "post_reset_p3");
        load(0, 8'hA0);
        load(3, 8'hA1);
        present();
        step();
        check("post_reset_p0", gnt, 4'b0001);
        drain(40, "post_reset_p0");

        // Connected 16-deep FIFO: 4 producers x 8 bytes
        use_fifo = 1'b1;
        rd_pct   = 25;
        wc0 = wcount; r0 = rd_count;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) load(i, 8'($urandom));
        present();
        drain(2000, "fifo32");
        hold = 0;
        while (ff_q.size() != 0 && hold < 500) begin
            step();
            hold++;
        end
        check("fifo32_written", wcount - wc0, 32);
        check("fifo32_read", rd_count - r0, 32);

        // Random traffic, random withdrawals, three drain rates
        for (int r = 0; r < 3; r++) begin
            rd_pct = (r == 0) ? 10 : (r == 1) ? 50 : 95;
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(99) < 30) load($urandom_range(NREQ - 1), 8'($urandom));
                drop = ($urandom_range(99) < 10) ? NREQ'($urandom) : '0;
                present();
                step();
            end
            drop = '0;
            present();
            drain(3000, "random");
        end

        for (int i = 0; i < NREQ; i++) check("sb_drained", rd_idx[i], exp_q[i].size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter NREQ, 4, number of producers sharing the FIFO write port.
REQ-003 Parameter DW, 8, data width, equal to the FIFO data width.
REQ-004 Parameter BURST, 4, maximum beats per grant (range 1..15).
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port req  input  NREQ  per-producer write request, level, held while data pending.
REQ-008 Port wdata  input  NREQ*DW  packed producer data; producer i occupies bits [i*DW +: DW].
REQ-009 Port fifo_full  input  1  FIFO full flag.
REQ-010 Port gnt  output  NREQ  registered one-hot grant, all-zero when idle.
REQ-011 Port ack  output  NREQ  one-cycle pulse on the owner's bit per accepted beat.
REQ-012 Port fifo_we  output  1  FIFO write enable.
REQ-013 Port fifo_din  output  DW  FIFO write data.
REQ-014 Port busy  output  1  high while in BURST.

Function
REQ-015 FSM states SHALL be IDLE and BURST.
REQ-016 In IDLE with req != 0, next edge: gnt = round-robin winner, state = BURST, beat count = 0.
REQ-017 Round-robin search SHALL start at index last+1 (mod NREQ) and wrap.
REQ-018 In IDLE with req == 0, state and gnt SHALL hold.
REQ-019 A beat SHALL be defined as state==BURST && req[owner] && !fifo_full.
REQ-020 fifo_we, fifo_din = wdata[owner] and ack[owner] SHALL be combinational from the beat condition, in the same cycle as the beat.
REQ-021 fifo_we SHALL never be high while fifo_full is high.
REQ-022 With fifo_full high in BURST: no beat, beat count holds, grant holds.
REQ-023 Each beat SHALL increment the beat count by 1.
REQ-024 BURST SHALL exit to IDLE on the edge after the BURST-th beat.
REQ-025 BURST SHALL also exit to IDLE on the edge after a cycle with req[owner] low.
REQ-026 On exit: last = owner, gnt = 0, count = 0; one IDLE cycle separates consecutive grants.
REQ-027 Request changes by non-owners during BURST SHALL have no effect until IDLE.
REQ-028 Latency: req rising in IDLE -> gnt and first beat (if not full) on the cycle after the next edge.

Reset
REQ-029 When rst_n is low, asynchronously: state = IDLE, gnt = 0, count = 0, last = NREQ-1, busy = 0.
REQ-030 While rst_n is low, fifo_we and ack SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no further beats.
REQ-032 After reset, producer 0 SHALL have first priority.

Structure
REQ-033 Package fifo_arb_pkg SHALL hold the state type, NREQ/DW/BURST defaults and the count width.
REQ-034 Sub-module rr_pick SHALL perform the combinational round-robin selection (inputs req and last; output one-hot winner).
REQ-035 The FIFO SHALL NOT be instantiated inside this block.

Verification
REQ-036 Bench: req=0001 held, wdata0 = 0x11..0x14, BURST=4 -> four beats, ack[0] x4, gnt=0001 for 4 cycles, then 1 IDLE cycle.
REQ-037 Bench: req=1111 held -> grant order 0,1,2,3,0 with 4 beats each and 1 idle cycle between grants.
REQ-038 Bench: owner 2 bursting, fifo_full high for 3 cycles after beat 2 -> fifo_we low for 3 cycles, count holds at 2, remaining 2 beats complete after full drops.
REQ-039 Bench: owner 1 drops req after 1 beat -> exit to IDLE on the next edge; req=0101 then grants producer 2.
REQ-040 Bench: rst_n pulsed low mid-burst at beat 2 -> gnt=0 and fifo_we=0 immediately; after release, req=1000 -> grants 3; req=1001 -> grants 0.
REQ-041 Bench: with connected 16-deep FIFO, 4 producers each write 8 bytes -> no write while full, all 32 bytes read back in grant order.
